// File: rtl/spi_bist_pkg.sv
// Shared types and MISR arithmetic for the BIST SPI responder.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package spi_bist_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SIG_W_DEF  = 4;

  // Feedback taps for x^4 + x^3 + 1: bits 3 and 2 feed the new LSB.
  localparam logic [SIG_W_DEF-1:0] MISR_TAPS = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // One MISR step: shift with feedback, then fold the byte's two nibbles in.
  function automatic logic [SIG_W_DEF-1:0] misr_next(input logic [SIG_W_DEF-1:0]  sig,
                                                     input logic [DATA_W_DEF-1:0] data);
    logic [SIG_W_DEF-1:0] fold;
    fold = data[7:4] ^ data[3:0];
    return {sig[SIG_W_DEF-2:0], ^(sig & MISR_TAPS)} ^ fold;
  endfunction

endpackage

// File: rtl/spi_bist_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with optional rise/fall strobes.
// Latency: STAGES cycles to the level output; strobes are valid in the cycle after that.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
module sync_edge #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  // Synchronizer chain; the reset level is chosen so a pin already at its
  // active level after reset does not look like a fresh edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Previous synchronized level, used to spot transitions.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= RST_VAL;
        else        prev_q <= dout;
      end

      // Both operands are flops, so the strobes are glitch-free single pulses.
      assign rise = dout & ~prev_q;
      assign fall = ~dout & prev_q;
    end else begin : g_level_only
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_bist_responder.sv
// SPI mode-0 responder: shifts in pattern bytes, returns a preloaded byte, compacts rx bytes into a MISR.
// Latency: rx_valid/rx_data/signature update SYNC_STAGES+1 clk after the 8th sclk rise at the pin.
// Backpressure: none on the SPI side; tx_load is accepted only while tx_ready, else ignored.
module spi_bist_responder
  import spi_bist_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SIG_W       = SIG_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              sig_clr,
  output logic [SIG_W-1:0]  signature,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sh, tx_sh, hold_q, rx_byte;
  logic              hold_full, complete, consume;

  // cs_n synchronizer resets low so an already-asserted chip select
  // cannot produce a falling strobe once reset releases.
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk), .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n), .dout(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi), .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  assign rx_byte  = {rx_sh[DATA_W-2:0], mosi_s};
  assign complete = (state == SHIFT) && !cs_rise && sclk_rise && (bit_cnt == LAST_BIT);
  assign consume  = (state == LOAD) || complete;
  assign tx_ready = ~hold_full;
  assign miso     = (state == SHIFT) & tx_sh[DATA_W-1];

  // Transmit holding register: consumption happens first, so a coincident
  // tx_load always lands in the freshly emptied register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else begin
      if (consume) hold_full <= 1'b0;
      if (tx_load && (!hold_full || consume)) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Frame FSM with the shift datapath, byte completion and MISR update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      signature <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // A completion below overrides this with the update applied to zero.
      if (sig_clr) signature <= '0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          tx_sh   <= hold_full ? hold_q : '0;
          bit_cnt <= '0;
          rx_sh   <= '0;
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            frame_err <= (bit_cnt != '0);
          end else if (sclk_rise) begin
            rx_sh <= rx_byte;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              rx_data   <= rx_byte;
              rx_valid  <= 1'b1;
              signature <= misr_next(sig_clr ? '0 : signature, rx_byte);
              tx_sh     <= hold_full ? hold_q : '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            // The fall right after a completion keeps the freshly loaded MSB.
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bist_responder.sv
// Self-checking bench for spi_bist_responder: directed scenarios plus randomized frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_bist_responder;

  logic       clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       tx_load = 1'b0, sig_clr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, tx_ready, rx_valid, frame_err, busy;
  logic [7:0] rx_data;
  logic [3:0] signature;

  int errors = 0, checks = 0;

  // Reference model state
  logic [7:0] exp_rx_q[$];
  logic [3:0] model_sig = 4'h0;
  logic [7:0] model_rx = 8'h00;
  logic       model_full = 1'b0;
  logic [7:0] model_val = 8'h00;
  logic [7:0] cur_resp = 8'h00;
  logic [7:0] last_got = 8'h00;
  int         ferr_expect = 0, ferr_cnt = 0, rxv_cnt = 0;
  int         half = 6;

  always #5 clk = ~clk;

  spi_bist_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .sig_clr(sig_clr),
    .signature(signature), .frame_err(frame_err), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature rule: shift left with x^4+x^3+1 feedback, then xor in the nibble fold.
  function automatic logic [3:0] model_misr(input logic [3:0] s, input logic [7:0] b);
    logic [3:0] shifted;
    shifted = {s[2:0], s[3] ^ s[2]};
    return shifted ^ (b[7:4] ^ b[3:0]);
  endfunction

  // Per-cycle comparison of the DUT against the model
  always @(posedge clk) begin : compare
    logic clr_now;
    clr_now = sig_clr;
    #1;
    if (reset) begin
      if (rx_valid) begin
        rxv_cnt++;
        chk("rx_valid_expected", exp_rx_q.size() != 0, 1);
        if (exp_rx_q.size() != 0) begin
          model_rx  = exp_rx_q.pop_front();
          model_sig = model_misr(clr_now ? 4'h0 : model_sig, model_rx);
        end
      end else if (clr_now) begin
        model_sig = 4'h0;
      end
      if (frame_err) begin
        ferr_cnt++;
        chk("frame_err_expected", ferr_expect > 0, 1);
        if (ferr_expect > 0) ferr_expect--;
      end
      chk("rx_data", rx_data, model_rx);
      chk("signature", signature, model_sig);
      if (!busy) chk("miso_idle", miso, 0);
    end else begin
      model_sig = 4'h0;
      model_rx  = 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic take_resp(output logic [7:0] r);
    r = model_full ? model_val : 8'h00;
    model_full = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    chk("tx_ready_before_load", tx_ready, !model_full);
    tx_data = v;
    tx_load = 1'b1;
    if (!model_full) begin
      model_full = 1'b1;
      model_val  = v;
    end
    @(negedge clk);
    tx_load = 1'b0;
    chk("tx_ready_after_load", tx_ready, !model_full);
  endtask

  task automatic pulse_clr();
    sig_clr = 1'b1;
    tick(1);
    sig_clr = 1'b0;
    tick(1);
  endtask

  task automatic cs_fall_t();
    cs_n = 1'b0;
    take_resp(cur_resp);
    tick(6);
    chk("busy_in_frame", busy, 1);
    chk("tx_ready_after_LOAD", tx_ready, !model_full);
  endtask

  task automatic cs_rise_t(input logic aborted);
    tick(half);
    if (aborted) ferr_expect++;
    cs_n = 1'b1;
    tick(8);
    chk("busy_after_frame", busy, 0);
    chk("rx_drained", exp_rx_q.size(), 0);
    chk("frame_err_seen", ferr_expect, 0);
  endtask

  // One byte (or partial byte) from the master, MSB first, mode 0.
  task automatic spi_byte(input logic [7:0] d, input int nbits, input logic expect_rx,
                          input logic ld, input logic [7:0] ld_val, input logic clr);
    logic [7:0] got, want;
    got  = 8'h00;
    want = cur_resp;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      if (ld && i == 2) begin
        do_load(ld_val);
        tick(half - 1);
      end else begin
        tick(half);
      end
      got  = {got[6:0], miso};
      sclk = 1'b1;
      if (i == 7 && expect_rx) begin
        exp_rx_q.push_back(d);
        take_resp(cur_resp);
      end
      if (i == 7 && clr) begin
        // Completion lands on the third clk edge after the pin-level rise.
        tick(2);
        sig_clr = 1'b1;
        tick(1);
        sig_clr = 1'b0;
        tick(half - 3);
      end else begin
        tick(half);
      end
      sclk = 1'b0;
    end
    last_got = got;
    if (nbits == 8 && expect_rx) chk("miso_byte", got, want);
  endtask

  initial begin : stim
    int base_rx, base_fe, nb, nbits;
    logic [7:0] rd, lv;
    logic ldr, clr;

    // Reset state
    tick(2);
    #1;
    chk("rst_miso", miso, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_signature", signature, 4'h0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(4);

    // Preloaded response, two back-to-back bytes in one frame
    do_load(8'h5A);
    cs_fall_t();
    base_rx = rxv_cnt;
    spi_byte(8'hA5, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_rx_A5", rx_data, 8'hA5);
    chk("lit_sig_F", signature, 4'hF);
    chk("lit_master_5A", last_got, 8'h5A);
    chk("lit_one_rx_valid", rxv_cnt - base_rx, 1);
    spi_byte(8'h3C, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_master_00", last_got, 8'h00);
    chk("lit_sig_1", signature, 4'h1);
    cs_rise_t(1'b0);

    // Frame aborted after 5 bits
    base_rx = rxv_cnt;
    base_fe = ferr_cnt;
    cs_fall_t();
    spi_byte(8'hFF, 5, 1'b1, 1'b0, 8'h00, 1'b0);
    cs_rise_t(1'b1);
    chk("lit_abort_ferr", ferr_cnt - base_fe, 1);
    chk("lit_abort_no_rx", rxv_cnt - base_rx, 0);
    chk("lit_abort_sig", signature, 4'h1);

    // Second load while full is ignored
    do_load(8'h11);
    do_load(8'h22);
    cs_fall_t();
    chk("lit_ready_after_LOAD", tx_ready, 1);
    spi_byte(8'h00, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_master_11", last_got, 8'h11);
    cs_rise_t(1'b0);

    // sig_clr alone, then coincident with a completion
    pulse_clr();
    chk("lit_sig_cleared", signature, 4'h0);
    cs_fall_t();
    spi_byte(8'hA5, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_sig_F_again", signature, 4'hF);
    spi_byte(8'h3C, 8, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("lit_sig_clr_fold", signature, 4'hF);
    cs_rise_t(1'b0);

    // Reset mid-byte
    do_load(8'h77);
    cs_fall_t();
    spi_byte(8'hC3, 3, 1'b1, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_signature", signature, 4'h0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_busy", busy, 0);
    exp_rx_q.delete();
    model_full  = 1'b0;
    ferr_expect = 0;
    tick(2);
    reset = 1'b1;
    tick(4);
    base_rx = rxv_cnt;
    spi_byte(8'h96, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("lit_no_rx_without_cs_fall", rxv_cnt - base_rx, 0);
    chk("lit_not_busy_stale_cs", busy, 0);
    cs_rise_t(1'b0);
    cs_fall_t();
    spi_byte(8'h96, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_rx_after_fresh_fall", rxv_cnt - base_rx, 1);
    cs_rise_t(1'b0);

    // Randomized frames
    for (int f = 0; f < 16; f++) begin
      half = int'($urandom_range(5, 8));
      if ($urandom_range(0, 3) == 0) pulse_clr();
      if ($urandom_range(0, 1) == 1) begin
        lv = 8'($urandom_range(0, 255));
        do_load(lv);
      end
      cs_fall_t();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        rd  = 8'($urandom_range(0, 255));
        lv  = 8'($urandom_range(0, 255));
        ldr = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 3) == 0);
        spi_byte(rd, 8, 1'b1, ldr, lv, clr);
      end
      if ($urandom_range(0, 3) == 0) begin
        rd    = 8'($urandom_range(0, 255));
        nbits = int'($urandom_range(1, 7));
        spi_byte(rd, nbits, 1'b1, 1'b0, 8'h00, 1'b0);
        cs_rise_t(1'b1);
      end else begin
        cs_rise_t(1'b0);
      end
    end

    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_bist_responder.md
# spi_bist_responder

SPI mode-0 slave (responder) for the BIST SPI link: receives 8-bit pattern bytes driven by the BIST SPI master, returns a pre-loaded response byte on MISO, and compacts every completed received byte into a 4-bit MISR signature. It sits at the far end of the link from the BIST master, so the self-test loop closes on chip. Its `signature` output is compared against the same golden signature sequence the BIST compare bench uses.

## Interface
- `DATA_W`, 8, frame width in bits (MSB first)
- `SIG_W`, 4, MISR signature width
- `SYNC_STAGES`, 2, synchronizer depth on `sclk`, `cs_n`, `mosi`

- `clk`  in  1  system clock; sole clock of the block
- `reset`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`
- `cs_n`  in  1  SPI chip select, active low, asynchronous
- `mosi`  in  1  serial data from master
- `miso`  out  1  serial data to master; driven 0 while `cs_n` is high
- `tx_data`  in  DATA_W  response byte to send
- `tx_load`  in  1  write strobe for `tx_data`
- `tx_ready`  out  1  transmit holding register is empty
- `rx_data`  out  DATA_W  last completed received byte
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated
- `sig_clr`  in  1  synchronous clear of the signature
- `signature`  out  SIG_W  running MISR signature
- `frame_err`  out  1  one-cycle pulse: `cs_n` rose mid-byte
- `busy`  out  1  frame active (synchronized `cs_n` low)

## Operation
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0x00, `rx_valid`=0, `signature`=0x0, `frame_err`=0, `busy`=0, holding register 0x00, bit counter 0, state IDLE.
- Synchronize `sclk`, `cs_n`, `mosi` through `SYNC_STAGES` flops. Derive one-cycle rise/fall strobes for `sclk` and `cs_n` from the synchronized signals.
- FSM states:
  - IDLE → LOAD on `cs_n` fall.
  - LOAD: copy the holding register into the TX shifter, mark the holding register empty, then → SHIFT. LOAD lasts exactly 1 cycle.
  - SHIFT → IDLE on `cs_n` rise.
- In SHIFT:
  - On each `sclk` rise, shift in synchronized `mosi` and increment the bit counter.
  - On an `sclk` fall, shift the TX shifter left only when the bit counter ≠ 0 (mid-byte).
  - `miso` = TX shifter MSB.
- Byte completion (8th `sclk` rise):
  - `rx_data` ← received byte, `rx_valid` pulses, bit counter ← 0.
  - TX shifter reloads from the holding register, or 0x00 if empty; the holding register is marked empty.
  - MISR update, fold f = byte[7:4] ^ byte[3:0]: sig ← {sig[2:0], sig[3]^sig[2]} ^ f (polynomial x⁴+x³+1).
- TX handshake:
  - `tx_load` while `tx_ready`=1 captures `tx_data`; `tx_ready` drops the next cycle.
  - `tx_load` while `tx_ready`=0 is ignored and the held value is kept.
  - `tx_ready` rises the cycle after LOAD or a completion reload.
- `cs_n` rise with bit counter ≠ 0: `frame_err` pulses; the partial byte is discarded; `signature` and `rx_data` are unchanged; the counter clears.
- `sig_clr`:
  - Alone: `signature` ← 0 next cycle.
  - Coincident with a byte completion: the MISR update is applied to 0, so new sig = f.
- `tx_load` coincident with a LOAD or reload: the consumption happens first, and the new value is captured into the now-empty register.
- Reset mid-frame: all state returns to reset values immediately. The block then waits for a fresh `cs_n` fall; an already-low `cs_n` does not start a frame.

## Timing
- `sclk` high and low phases must each be ≥ 4 `clk` periods. `cs_n` setup to the first `sclk` rise must be ≥ 4 `clk` periods.
- Pin-to-strobe latency is `SYNC_STAGES`+1 cycles; `rx_valid` is asserted 3 `clk` after the pin-level 8th `sclk` rise.
- `rx_data` and `signature` change on the same edge `rx_valid` goes high.
- `miso` is valid ≤ `SYNC_STAGES`+2 cycles after a `cs_n` fall or an `sclk` fall, well before the next `sclk` rise.
- Back-to-back bytes within one frame require no gap cycles.

## Structure
- Package `spi_bist_pkg`:
  - state enum (IDLE, LOAD, SHIFT)
  - `DATA_W` / `SIG_W` defaults
  - MISR tap constant 4'b1100
  - MISR next-state function
- Sub-module `sync_edge`: `SYNC_STAGES`-deep synchronizer with registered rise/fall strobes. It is instantiated for `sclk` and `cs_n`; `mosi` uses synchronizer-only mode.

## Test plan
- Preload 0x5A, run a frame sending 0xA5 → `rx_data`=0xA5, one `rx_valid` pulse, master receives 0x5A, `signature`=0xF.
- In the same frame, send a second byte 0x3C with no preload → master receives 0x00, `signature`=0x1.
- Raise `cs_n` after 5 bits of 0xFF → `frame_err` pulse, `rx_valid` stays 0, `signature` unchanged.
- `tx_load`=0x11 then `tx_load`=0x22 before any frame → master receives 0x11; `tx_ready` returns to 1 after LOAD.
- Assert `sig_clr` on the `rx_valid` cycle for byte 0x3C with sig=0xF → `signature`=0xF (= f).
- Assert `reset` mid-byte → all outputs return to reset values at once; no `rx_valid` is generated until the next `cs_n` fall.
